// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder controller: one shared single-digit BCD cell,
// least-significant digit first, one digit per clock, registered result + done pulse.
module bcd_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d, err_pend_q, err_pend_d;
  logic            cout_q, cout_d, err_q, err_d;

  logic [W-1:0]    a_shift, b_shift;
  logic [3:0]      dig_a, dig_b, dig_s;
  logic [4:0]      raw;
  logic            dig_c, any_bad;

  // Shared single-digit BCD adder cell; result for non-decimal digits is masked later.
  always_comb begin
    a_shift = a_q >> {idx_q, 2'b00};
    b_shift = b_q >> {idx_q, 2'b00};
    dig_a   = a_shift[3:0];
    dig_b   = b_shift[3:0];
    raw     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
    if (raw > 5'd9) begin
      dig_s = 4'(raw + 5'd6);
      dig_c = 1'b1;
    end else begin
      dig_s = raw[3:0];
      dig_c = 1'b0;
    end
  end

  always_comb begin
    any_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (op_a[4*i +: 4] > 4'd9 || op_b[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    err_pend_d = err_pend_q;
    cout_d     = cout_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = op_a;
          b_d        = op_b;
          carry_d    = cin;
          idx_d      = '0;
          res_d      = '0;
          err_pend_d = any_bad;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (IW'(i) == idx_q) res_d[4*i +: 4] = dig_s;
        end
        carry_d = dig_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(DIGITS - 1)) begin
          // res_d already holds the last digit written above.
          state_d = S_DONE;
          idx_d   = '0;
          sum_d   = err_pend_q ? '0 : res_d;
          cout_d  = err_pend_q ? 1'b0 : dig_c;
          err_d   = err_pend_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      err_pend_q <= 1'b0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      err_pend_q <= err_pend_d;
      cout_q     <= cout_d;
      err_q      <= err_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed self-checking bench for bcd_serial_adder_ctrl (DIGITS=4).
module tb_bcd_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns just after the start edge E0.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Number of edges after E0 until done is seen; -1 if it never arrives.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({busy, done, sum, cout, err} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, expected 00000", {busy, done, sum, cout, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int busy_cnt;
    busy_cnt = 0;
    launch(16'h1234, 16'h5678, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
      if (k < 3) tick();
    end
    n_cmp++;
    if (busy_cnt !== 4) begin
      n_bad++;
      $display("FAIL basic_busy: busy cycles %0d, expected 4", busy_cnt);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_timing: done=%b busy=%b, expected done=1 busy=0", done, busy);
    end
    n_cmp++;
    if (sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_result: sum=%h cout=%b err=%b, expected 6912 0 0", sum, cout, err);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_carry();
    int cyc;
    launch(16'h9999, 16'h0001, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || sum !== 16'h0000 || cout !== 1'b1) begin
      n_bad++;
      $display("FAIL carry_wrap: lat=%0d sum=%h cout=%b, expected 4 0000 1", cyc, sum, cout);
    end
    tick();
    launch(16'h9999, 16'h9999, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || sum !== 16'h9999 || cout !== 1'b1) begin
      n_bad++;
      $display("FAIL carry_max: lat=%0d sum=%h cout=%b, expected 4 9999 1", cyc, sum, cout);
    end
    tick();
  endtask

  task automatic test_err();
    int cyc;
    launch(16'h12A4, 16'h0001, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || err !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL err_flag: lat=%0d err=%b sum=%h cout=%b, expected 4 1 0000 0", cyc, err, sum, cout);
    end
    tick();
    launch(16'h0005, 16'h0005, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || err !== 1'b0 || sum !== 16'h0010 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear: lat=%0d err=%b sum=%h cout=%b, expected 4 0 0010 0", cyc, err, sum, cout);
    end
    tick();
  endtask

  task automatic test_no_restart();
    int cyc;
    int extra;
    extra = 0;
    launch(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    op_a  = 16'h9999;
    start = 1'b1;
    wait_done(cyc);
    start = 1'b0;
    n_cmp++;
    if (cyc !== 2 || sum !== 16'h3333 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL no_restart_result: lat=%0d sum=%h cout=%b, expected 2 3333 0", cyc, sum, cout);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++;
      $display("FAIL no_restart_single: extra activity cycles %0d, expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int spurious;
    spurious = 0;
    launch(16'h1234, 16'h5678, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, sum, cout, err} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %h, expected 00000", {busy, done, sum, cout, err});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) spurious++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) spurious++;
    end
    n_cmp++;
    if (spurious !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done: activity cycles %0d, expected 0", spurious);
    end
    launch(16'h0005, 16'h0005, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || sum !== 16'h0010 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_recover: lat=%0d sum=%h err=%b, expected 4 0010 0", cyc, sum, err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int ndone;
    int overlap;
    int bad_sum;
    int bad_gap;
    int last;
    ndone = 0; overlap = 0; bad_sum = 0; bad_gap = 0; last = -1;
    op_a  = 16'h4321;
    op_b  = 16'h1111;
    cin   = 1'b0;
    start = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (busy === 1'b1 && done === 1'b1) overlap++;
      if (done === 1'b1) begin
        ndone++;
        if (sum !== 16'h5432) bad_sum++;
        if (last >= 0 && t - last != 6) bad_gap++;
        if (last < 0 && t != 5) bad_gap++;
        last = t;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (ndone !== 3) begin
      n_bad++;
      $display("FAIL b2b_count: done pulses %0d, expected 3", ndone);
    end
    n_cmp++;
    if (bad_gap !== 0 || bad_sum !== 0) begin
      n_bad++;
      $display("FAIL b2b_spacing: bad gaps %0d bad sums %0d, expected 0 0", bad_gap, bad_sum);
    end
    n_cmp++;
    if (overlap !== 0) begin
      n_bad++;
      $display("FAIL b2b_overlap: busy&done cycles %0d, expected 0", overlap);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_err();
    test_no_restart();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
